data_mem_wait: RTL and testbench

//  Parametrised MEM-stage data memory with configurable access latency. Adds byte, halfword and word accesses,

---
 rtl/data_mem_pkg.sv | 19 +
 rtl/mem_lane_align.sv | 54 +++++
 rtl/data_mem_wait.sv | 144 ++++++++++++++
 tb/tb_data_mem_wait.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared definitions for the MEM-stage data memory: access size codes and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package data_mem_pkg;

  // Access size encodings carried on the size port
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Access sequencer states; values fixed so traces stay comparable across revisions
  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: merges store data into a word and extracts load data from a word.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   word           in   32  current contents of the addressed memory word
//   lane           in   2   byte offset within the word
//   size           in   2   access size (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_ILL)
//   wdata          in   32  store data, sub-word stores use the low bits
//   merged_word    out  32  word with the store data merged into the addressed lanes
//   extracted_data out  32  addressed lanes of word, zero-extended
//   misalign       out  1   halfword on an odd lane, or word on a non-zero lane
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] merged_word,
  output logic [31:0] extracted_data,
  output logic        misalign
);

  always_comb begin
    merged_word    = word;
    extracted_data = '0;
    misalign       = 1'b0;
    case (size)
      SZ_BYTE: begin
        merged_word[8*lane +: 8]  = wdata[7:0];
        extracted_data[7:0]       = word[8*lane +: 8];
      end
      SZ_HALF: begin
        // Only lane[1] selects the half; an odd lane is flagged and the access is dropped upstream
        merged_word[16*lane[1] +: 16] = wdata[15:0];
        extracted_data[15:0]          = word[16*lane[1] +: 16];
        misalign                      = lane[0];
      end
      SZ_WORD: begin
        merged_word    = wdata;
        extracted_data = word;
        misalign       = |lane;
      end
      default: begin
        // Illegal size is reported by the caller; leave the word untouched
        merged_word    = word;
        extracted_data = '0;
        misalign       = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_wait.sv
// MEM-stage data memory with fixed multi-cycle access latency, sub-word access and range checking.
// Latency: request in cycle T, result and ready in cycle T+WAIT_CYCLES+1.
// Backpressure: stall freezes the pipeline from the request cycle until the DONE cycle.
//
// Ports:
//   clk       in   1       clock, rising edge
//   rst       in   1       asynchronous active-low reset
//   alu_res   in   ADDR_W  byte address
//   val_rm    in   DATA_W  store data
//   mem_w_en  in   1       store request (level)
//   mem_r_en  in   1       load request (level)
//   size      in   2       access size
//   res_data  out  DATA_W  registered, zero-extended load result
//   stall     out  1       pipeline freeze request (combinational)
//   ready     out  1       one-cycle completion pulse
//   addr_err  out  1       one-cycle fault pulse, coincident with ready
module data_mem_wait
  import data_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] alu_res,
  input  logic [DATA_W-1:0] val_rm,
  input  logic              mem_w_en,
  input  logic              mem_r_en,
  input  logic [1:0]        size,
  output logic [DATA_W-1:0] res_data,
  output logic              stall,
  output logic              ready,
  output logic              addr_err
);

  localparam int                IDX_W    = $clog2(DEPTH);
  localparam logic [3:0]        CNT_INIT = 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-3:0] DEPTH_W  = (ADDR_W-2)'(DEPTH);

  mem_state_e        r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_is_wr;
  logic [1:0]        r_size;
  logic [DATA_W-1:0] r_res_data;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_req;
  logic              w_commit;
  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-3:0] w_idx_full;
  logic [IDX_W-1:0]  w_idx;
  logic [1:0]        w_lane;
  logic              w_below;
  logic              w_range;
  logic              w_misalign;
  logic              w_fault;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_extract;

  assign w_req    = mem_r_en | mem_w_en;
  assign w_commit = (r_state == MEM_BUSY) && (r_cnt == 4'd0);

  // All address decoding works on the latched request, so input changes mid-access are ignored
  assign w_off      = r_addr - BASE;
  assign w_idx_full = w_off[ADDR_W-1:2];
  assign w_idx      = w_idx_full[IDX_W-1:0];
  assign w_lane     = w_off[1:0];
  assign w_below    = r_addr < BASE;
  assign w_range    = w_idx_full >= DEPTH_W;
  assign w_fault    = w_below | w_range | (r_size == SZ_ILL) | w_misalign;

  mem_lane_align u_align (
    .word           (r_mem[w_idx]),
    .lane           (w_lane),
    .size           (r_size),
    .wdata          (r_wdata),
    .merged_word    (w_merged),
    .extracted_data (w_extract),
    .misalign       (w_misalign)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= MEM_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_wr    <= 1'b0;
      r_size     <= SZ_BYTE;
      r_res_data <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        MEM_IDLE: begin
          if (w_req) begin
            r_addr  <= alu_res;
            r_wdata <= val_rm;
            r_is_wr <= mem_w_en;  // both enables together count as a store
            r_size  <= size;
            r_cnt   <= CNT_INIT;
            r_state <= MEM_BUSY;
          end
        end
        MEM_BUSY: begin
          if (r_cnt == 4'd0) begin
            r_res_data <= (!r_is_wr && !w_fault) ? w_extract : '0;
            r_err      <= w_fault;
            r_state    <= MEM_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        MEM_DONE: begin
          // The still-held request belongs to the instruction just completed
          r_state <= MEM_IDLE;
        end
        default: r_state <= MEM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_commit && r_is_wr && !w_fault) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  assign res_data = r_res_data;
  assign ready    = (r_state == MEM_DONE);
  assign addr_err = ready & r_err;
  assign stall    = rst & (((r_state == MEM_IDLE) & w_req) | (r_state == MEM_BUSY));

endmodule

// File: tb/tb_data_mem_wait.sv
module tb_data_mem_wait;
  import data_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_res;
  logic [31:0] val_rm;
  logic        mem_w_en;
  logic        mem_r_en;
  logic [1:0]  size;
  logic [31:0] res_data;
  logic        stall;
  logic        ready;
  logic        addr_err;

  data_mem_wait dut (
    .clk      (clk),
    .rst      (rst),
    .alu_res  (alu_res),
    .val_rm   (val_rm),
    .mem_w_en (mem_w_en),
    .mem_r_en (mem_r_en),
    .size     (size),
    .res_data (res_data),
    .stall    (stall),
    .ready    (ready),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    logic        r;
    logic [1:0]  sz;
    logic [31:0] exp;
    logic        err;
  } op_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Drives one request (caller sits just after a rising edge) and waits for ready.
  task automatic run_access(input logic [31:0] a, input logic [31:0] d, input logic w,
                            input logic r, input logic [1:0] sz, input logic hold,
                            output logic [31:0] res, output logic err, output int stall_cyc,
                            output int lat, output logic stall_done, output logic to);
    alu_res  = a;
    val_rm   = d;
    mem_w_en = w;
    mem_r_en = r;
    size     = sz;
    stall_cyc  = 0;
    lat        = -1;
    to         = 1'b1;
    res        = '0;
    err        = 1'b0;
    stall_done = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready) begin
        lat        = c;
        res        = res_data;
        err        = addr_err;
        stall_done = stall;
        to         = 1'b0;
        break;
      end
      if (stall) stall_cyc++;
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      mem_w_en = 1'b0;
      mem_r_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    alu_res  = 32'd1024;
    val_rm   = '0;
    mem_w_en = 1'b0;
    mem_r_en = 1'b1;  // request present during reset must not raise stall
    size     = SZ_WORD;
    repeat (2) @(negedge clk);
    n_checks++; if (res_data !== 32'h0) begin n_fail++; $display("FAIL reset res_data: got %h expected 00000000", res_data); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset ready: got %b expected 0", ready); end
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset addr_err: got %b expected 0", addr_err); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset stall: got %b expected 0", stall); end
    @(posedge clk);
    #1;
    mem_r_en = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL idle stall: got %b expected 0", stall); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_word_rw();
    logic [31:0] res; logic err, sd, to; int sc, lat; exp_t e;
    sb.push_back('{32'h0, 1'b0});
    run_access(32'd1024, 32'hDEADBEEF, 1'b1, 1'b0, SZ_WORD, 1'b0, res, err, sc, lat, sd, to);
    e = sb.pop_front();
    n_checks++; if (to || res !== e.res || err !== e.err) begin n_fail++; $display("FAIL word_write result: got %h/%b to=%b expected %h/%b", res, err, to, e.res, e.err); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL word_write latency: got %0d expected 4", lat); end
    n_checks++; if (sc !== 4) begin n_fail++; $display("FAIL word_write stall cycles: got %0d expected 4", sc); end
    n_checks++; if (sd !== 1'b0) begin n_fail++; $display("FAIL word_write stall at done: got %b expected 0", sd); end
    sb.push_back('{32'hDEADBEEF, 1'b0});
    run_access(32'd1024, 32'h0, 1'b0, 1'b1, SZ_WORD, 1'b0, res, err, sc, lat, sd, to);
    e = sb.pop_front();
    n_checks++; if (to || res !== e.res || err !== e.err) begin n_fail++; $display("FAIL word_read result: got %h/%b to=%b expected %h/%b", res, err, to, e.res, e.err); end
    n_checks++; if (lat !== 4 || sc !== 4) begin n_fail++; $display("FAIL word_read timing: got lat %0d stall %0d expected 4/4", lat, sc); end
  endtask

  task automatic test_byte_merge();
    op_t ops[$];
    logic [31:0] res; logic err, sd, to; int sc, lat; exp_t e;
    ops.push_back('{32'd1028, 32'h11223344, 1'b1, 1'b0, SZ_WORD, 32'h0, 1'b0});
    ops.push_back('{32'd1029, 32'hFFFFFFAA, 1'b1, 1'b0, SZ_BYTE, 32'h0, 1'b0});
    ops.push_back('{32'd1028, 32'h0,        1'b0, 1'b1, SZ_WORD, 32'h1122AA44, 1'b0});
    ops.push_back('{32'd1031, 32'h0,        1'b0, 1'b1, SZ_BYTE, 32'h00000011, 1'b0});
    ops.push_back('{32'd1030, 32'h1234BEEF, 1'b1, 1'b0, SZ_HALF, 32'h0, 1'b0});
    ops.push_back('{32'd1028, 32'h0,        1'b0, 1'b1, SZ_WORD, 32'hBEEFAA44, 1'b0});
    ops.push_back('{32'd1030, 32'h0,        1'b0, 1'b1, SZ_HALF, 32'h0000BEEF, 1'b0});
    ops.push_back('{32'd1029, 32'h0,        1'b0, 1'b1, SZ_BYTE, 32'h000000AA, 1'b0});
    foreach (ops[i]) begin
      sb.push_back('{ops[i].exp, ops[i].err});
      run_access(ops[i].a, ops[i].d, ops[i].w, ops[i].r, ops[i].sz, 1'b0, res, err, sc, lat, sd, to);
      e = sb.pop_front();
      n_checks++; if (to || res !== e.res) begin n_fail++; $display("FAIL merge[%0d] res_data: got %h to=%b expected %h", i, res, to, e.res); end
      n_checks++; if (err !== e.err) begin n_fail++; $display("FAIL merge[%0d] addr_err: got %b expected %b", i, err, e.err); end
    end
  endtask

  task automatic test_faults();
    op_t ops[$];
    logic [31:0] res; logic err, sd, to; int sc, lat; exp_t e;
    ops.push_back('{32'd1020, 32'h12345678, 1'b1, 1'b0, SZ_WORD, 32'h0, 1'b1});
    ops.push_back('{32'd1280, 32'h12345678, 1'b1, 1'b0, SZ_WORD, 32'h0, 1'b1});
    ops.push_back('{32'd1025, 32'h12345678, 1'b1, 1'b0, SZ_HALF, 32'h0, 1'b1});
    ops.push_back('{32'd1028, 32'h12345678, 1'b1, 1'b0, SZ_ILL,  32'h0, 1'b1});
    ops.push_back('{32'd1024, 32'h0, 1'b0, 1'b1, SZ_WORD, 32'hDEADBEEF, 1'b0});
    ops.push_back('{32'd1020, 32'h0, 1'b0, 1'b1, SZ_WORD, 32'h0, 1'b1});
    ops.push_back('{32'd1276, 32'h0, 1'b0, 1'b1, SZ_WORD, 32'h0, 1'b0});
    ops.push_back('{32'd1028, 32'h0, 1'b0, 1'b1, SZ_WORD, 32'hBEEFAA44, 1'b0});
    ops.push_back('{32'd1026, 32'h0, 1'b0, 1'b1, SZ_WORD, 32'h0, 1'b1});
    ops.push_back('{32'd1028, 32'h0, 1'b0, 1'b1, SZ_ILL,  32'h0, 1'b1});
    foreach (ops[i]) begin
      sb.push_back('{ops[i].exp, ops[i].err});
      run_access(ops[i].a, ops[i].d, ops[i].w, ops[i].r, ops[i].sz, 1'b0, res, err, sc, lat, sd, to);
      e = sb.pop_front();
      n_checks++; if (to || res !== e.res) begin n_fail++; $display("FAIL fault[%0d] res_data: got %h to=%b expected %h", i, res, to, e.res); end
      n_checks++; if (err !== e.err) begin n_fail++; $display("FAIL fault[%0d] addr_err: got %b expected %b", i, err, e.err); end
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL fault[%0d] latency: got %0d expected 4", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; logic err, sd, to; int sc, lat; exp_t e;
    sb.push_back('{32'h0, 1'b0});
    run_access(32'd1040, 32'hCAFE0001, 1'b1, 1'b0, SZ_WORD, 1'b1, res, err, sc, lat, sd, to);
    e = sb.pop_front();
    n_checks++; if (to || res !== e.res || lat !== 4) begin n_fail++; $display("FAIL b2b first: got %h lat %0d to=%b expected %h lat 4", res, lat, to, e.res); end
    n_checks++; if (sd !== 1'b0) begin n_fail++; $display("FAIL b2b stall at done: got %b expected 0", sd); end
    sb.push_back('{32'hCAFE0001, 1'b0});
    run_access(32'd1040, 32'h0, 1'b0, 1'b1, SZ_WORD, 1'b0, res, err, sc, lat, sd, to);
    e = sb.pop_front();
    n_checks++; if (to || res !== e.res || err !== e.err) begin n_fail++; $display("FAIL b2b second result: got %h/%b to=%b expected %h/%b", res, err, to, e.res, e.err); end
    n_checks++; if (lat !== 4 || sc !== 4) begin n_fail++; $display("FAIL b2b second timing: got lat %0d stall %0d expected 4/4", lat, sc); end
  endtask

  task automatic test_both_en();
    logic [31:0] res; logic err, sd, to; int sc, lat; exp_t e;
    sb.push_back('{32'h0, 1'b0});
    run_access(32'd1032, 32'd5, 1'b1, 1'b1, SZ_WORD, 1'b0, res, err, sc, lat, sd, to);
    e = sb.pop_front();
    n_checks++; if (to || res !== e.res || err !== e.err) begin n_fail++; $display("FAIL both_en result: got %h/%b to=%b expected %h/%b", res, err, to, e.res, e.err); end
    sb.push_back('{32'd5, 1'b0});
    run_access(32'd1032, 32'h0, 1'b0, 1'b1, SZ_WORD, 1'b0, res, err, sc, lat, sd, to);
    e = sb.pop_front();
    n_checks++; if (to || res !== e.res) begin n_fail++; $display("FAIL both_en readback: got %h to=%b expected %h", res, to, e.res); end
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] res; logic err, sd, to; int sc, lat; exp_t e;
    // res_data still holds 5 from the previous load
    alu_res  = 32'd1036;
    val_rm   = 32'h77;
    mem_w_en = 1'b1;
    mem_r_en = 1'b0;
    size     = SZ_WORD;
    @(negedge clk);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_mid request stall: got %b expected 1", stall); end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (res_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid res_data: got %h expected 00000000", res_data); end
    n_checks++; if (stall !== 1'b0 || ready !== 1'b0 || addr_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid outputs: got stall %b ready %b err %b expected 0/0/0", stall, ready, addr_err); end
    mem_w_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid idle stall: got %b expected 0", stall); end
    @(posedge clk);
    #1;
    sb.push_back('{32'h0, 1'b0});
    run_access(32'd1036, 32'h0, 1'b0, 1'b1, SZ_WORD, 1'b0, res, err, sc, lat, sd, to);
    e = sb.pop_front();
    n_checks++; if (to || res !== e.res || lat !== 4) begin n_fail++; $display("FAIL rst_mid read 1036: got %h lat %0d to=%b expected %h lat 4", res, lat, to, e.res); end
    sb.push_back('{32'h0, 1'b0});
    run_access(32'd1024, 32'h0, 1'b0, 1'b1, SZ_WORD, 1'b0, res, err, sc, lat, sd, to);
    e = sb.pop_front();
    n_checks++; if (to || res !== e.res) begin n_fail++; $display("FAIL rst_mid cleared 1024: got %h to=%b expected %h", res, to, e.res); end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_merge();
    test_faults();
    test_back_to_back();
    test_both_en();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
